// File: rtl/i2c_arb.sv
// i2c_arb: round-robin arbiter and retrying transaction sequencer in front of one I2C master engine
module i2c_arb #(
   parameter int NREQ      = 4,
   parameter int RETRIES   = 2,
   parameter int RETRY_GAP = 64
) (
   input  logic                    clk_i,
   input  logic                    srst_i,
   input  logic [NREQ-1:0]         req_val_i,
   input  logic [7*NREQ-1:0]       req_daddr_i,
   input  logic [8*NREQ-1:0]       req_addr_i,
   input  logic [8*NREQ-1:0]       req_data_i,
   input  logic [NREQ-1:0]         req_wen_i,
   output logic [NREQ-1:0]         req_rdy_o,
   output logic [NREQ-1:0]         resp_val_o,
   output logic                    resp_err_o,
   output logic [7:0]              resp_data_o,
   input  logic [NREQ-1:0]         resp_rdy_i,
   output logic                    i2c_val_o,
   output logic [6:0]              i2c_daddr_o,
   output logic [7:0]              i2c_addr_o,
   output logic [7:0]              i2c_data_o,
   output logic                    i2c_wen_o,
   input  logic                    i2c_rdy_i,
   input  logic                    i2c_out_val_i,
   input  logic                    i2c_out_err_i,
   input  logic [7:0]              i2c_out_data_i,
   output logic                    i2c_out_rdy_o,
   output logic                    busy_o,
   output logic [$clog2(NREQ)-1:0] grant_o,
   output logic [15:0]             fail_cnt_o
);
   localparam int GW = $clog2(NREQ);
   localparam int CW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, RESP} state_t;
   state_t          r_state;
   logic [GW-1:0]   r_grant, r_last, w_win;
   logic            w_any;
   logic [6:0]      r_daddr;
   logic [7:0]      r_addr, r_data, r_rdata;
   logic            r_wen, r_val, r_out_rdy, r_err;
   logic [NREQ-1:0] r_resp_val;
   logic [3:0]      r_att;
   logic [CW-1:0]   r_gap;
   logic [15:0]     r_fail;
   // first requester after the last owner, scanning with wrap; the nearest one overrides
   always_comb begin
      int k;
      k     = 0;
      w_win = '0;
      w_any = 1'b0;
      for (int i = NREQ; i >= 1; i--) begin
         k = (int'(r_last) + i) % NREQ;
         if (req_val_i[k]) begin
            w_win = GW'(k);
            w_any = 1'b1;
         end
      end
   end
   assign req_rdy_o     = (r_state == IDLE && w_any && !srst_i) ? NREQ'(1) << w_win : '0;
   assign i2c_val_o     = r_val;
   assign i2c_daddr_o   = r_val ? r_daddr : '0;
   assign i2c_addr_o    = r_val ? r_addr : '0;
   assign i2c_data_o    = r_val ? r_data : '0;
   assign i2c_wen_o     = r_val & r_wen;
   assign i2c_out_rdy_o = r_out_rdy;
   assign resp_val_o    = r_resp_val;
   assign resp_err_o    = |r_resp_val & r_err;
   assign resp_data_o   = |r_resp_val ? r_rdata : '0;
   assign busy_o        = r_state != IDLE;
   assign grant_o       = r_grant;
   assign fail_cnt_o    = r_fail;
   // sequencer: grant, issue, await completion, space out retries, hold the response
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_state    <= IDLE;
         r_grant    <= '0;
         r_last     <= GW'(NREQ - 1);
         r_daddr    <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_wen      <= 1'b0;
         r_val      <= 1'b0;
         r_out_rdy  <= 1'b0;
         r_err      <= 1'b0;
         r_rdata    <= '0;
         r_resp_val <= '0;
         r_att      <= '0;
         r_gap      <= '0;
         r_fail     <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_daddr <= req_daddr_i[7*w_win +: 7];
               r_addr  <= req_addr_i[8*w_win +: 8];
               r_data  <= req_data_i[8*w_win +: 8];
               r_wen   <= req_wen_i[w_win];
               r_grant <= w_win;
               r_att   <= '0;
               r_val   <= 1'b1;
               r_state <= ISSUE;
            end
            ISSUE: if (i2c_rdy_i) begin
               r_val     <= 1'b0;
               r_out_rdy <= 1'b1;
               r_state   <= WAIT;
            end
            WAIT: if (i2c_out_val_i) begin
               r_out_rdy <= 1'b0;
               r_err     <= i2c_out_err_i;
               r_rdata   <= i2c_out_data_i;
               if (i2c_out_err_i && r_att < 4'(RETRIES)) begin
                  r_att   <= r_att + 4'd1;
                  r_gap   <= CW'(RETRY_GAP - 1);
                  r_state <= GAP;
               end else begin
                  r_resp_val <= NREQ'(1) << r_grant;
                  r_state    <= RESP;
               end
            end
            GAP: if (r_gap == '0) begin
               r_val   <= 1'b1;
               r_state <= ISSUE;
            end else begin
               r_gap <= r_gap - CW'(1);
            end
            RESP: if (resp_rdy_i[r_grant]) begin
               r_resp_val <= '0;
               r_last     <= r_grant;
               if (r_err && r_fail != 16'hFFFF) r_fail <= r_fail + 16'd1;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_arb.sv
// tb_i2c_arb: randomized self-checking bench for i2c_arb against a transaction-level model
module tb_i2c_arb;
   localparam int NREQ = 4, RETRIES = 2, RETRY_GAP = 64;
   logic                clk = 1'b0;
   logic                srst_i;
   logic [NREQ-1:0]     req_val_i, req_rdy_o, resp_val_o, resp_rdy_i, req_wen_i;
   logic [7*NREQ-1:0]   req_daddr_i;
   logic [8*NREQ-1:0]   req_addr_i, req_data_i;
   logic                resp_err_o, i2c_val_o, i2c_wen_o, i2c_rdy_i, i2c_out_val_i, i2c_out_err_i;
   logic                i2c_out_rdy_o, busy_o;
   logic [7:0]          resp_data_o, i2c_addr_o, i2c_data_o, i2c_out_data_i;
   logic [6:0]          i2c_daddr_o;
   logic [1:0]          grant_o;
   logic [15:0]         fail_cnt_o;
   logic [6:0]          f_daddr [NREQ];
   logic [7:0]          f_addr [NREQ], f_data [NREQ];
   logic                f_wen [NREQ];
   int                  checks = 0, failures = 0, m_last, m_fail, n_hs = 0, w;
   int                  wins[$];
   int                  rr_exp [5] = '{0, 1, 2, 3, 0};

   i2c_arb #(.NREQ(NREQ), .RETRIES(RETRIES), .RETRY_GAP(RETRY_GAP)) dut (
      .clk_i(clk), .srst_i(srst_i), .req_val_i(req_val_i), .req_daddr_i(req_daddr_i),
      .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_wen_i(req_wen_i),
      .req_rdy_o(req_rdy_o), .resp_val_o(resp_val_o), .resp_err_o(resp_err_o),
      .resp_data_o(resp_data_o), .resp_rdy_i(resp_rdy_i), .i2c_val_o(i2c_val_o),
      .i2c_daddr_o(i2c_daddr_o), .i2c_addr_o(i2c_addr_o), .i2c_data_o(i2c_data_o),
      .i2c_wen_o(i2c_wen_o), .i2c_rdy_i(i2c_rdy_i), .i2c_out_val_i(i2c_out_val_i),
      .i2c_out_err_i(i2c_out_err_i), .i2c_out_data_i(i2c_out_data_i),
      .i2c_out_rdy_o(i2c_out_rdy_o), .busy_o(busy_o), .grant_o(grant_o), .fail_cnt_o(fail_cnt_o)
   );

   always #5 clk = ~clk;

   // flatten per-requester fields onto the packed request buses
   always_comb begin
      req_daddr_i = '0;
      req_addr_i  = '0;
      req_data_i  = '0;
      req_wen_i   = '0;
      for (int k = 0; k < NREQ; k++) begin
         req_daddr_i[7*k +: 7] = f_daddr[k];
         req_addr_i[8*k +: 8]  = f_addr[k];
         req_data_i[8*k +: 8]  = f_data[k];
         req_wen_i[k]          = f_wen[k];
      end
   end

   // independent count of engine request handshakes
   always @(posedge clk) if (!srst_i && i2c_val_o && i2c_rdy_i) n_hs <= n_hs + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      for (int i = 1; i <= NREQ; i++) if (v[(last + i) % NREQ]) return (last + i) % NREQ;
      return -1;
   endfunction

   task automatic rand_fields();
      for (int k = 0; k < NREQ; k++) begin
         f_daddr[k] = 7'($urandom);
         f_addr[k]  = 8'($urandom);
         f_data[k]  = 8'($urandom);
         f_wen[k]   = 1'($urandom);
      end
   endtask

   task automatic do_reset();
      srst_i = 1'b1;
      req_val_i = '0; resp_rdy_i = '0; i2c_rdy_i = 1'b0;
      i2c_out_val_i = 1'b0; i2c_out_err_i = 1'b0; i2c_out_data_i = '0;
      @(posedge clk); @(negedge clk);
      srst_i = 1'b0;
      m_last = NREQ - 1;
      m_fail = 0;
   endtask

   task automatic chk_idle_zero(input string tag);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_i2c_val"}, i2c_val_o, 0);
      chk({tag, "_out_rdy"}, i2c_out_rdy_o, 0);
      chk({tag, "_resp_val"}, resp_val_o, 0);
      chk({tag, "_grant"}, grant_o, 0);
      chk({tag, "_fail_cnt"}, fail_cnt_o, 0);
      chk({tag, "_daddr"}, i2c_daddr_o, 0);
   endtask

   task automatic chk_eng(input int k);
      chk("i2c_val", i2c_val_o, 1);
      chk("i2c_daddr", i2c_daddr_o, f_daddr[k]);
      chk("i2c_addr", i2c_addr_o, f_addr[k]);
      chk("i2c_data", i2c_data_o, f_data[k]);
      chk("i2c_wen", i2c_wen_o, f_wen[k]);
   endtask

   // one engine attempt: random accept delay, random completion latency
   task automatic attempt(input int k, input bit err, input logic [7:0] d);
      int dl = $urandom_range(0, 3);
      repeat (dl) begin
         chk_eng(k);
         @(posedge clk); @(negedge clk);
      end
      chk_eng(k);
      i2c_rdy_i = 1'b1;
      @(posedge clk); @(negedge clk);
      i2c_rdy_i = 1'b0;
      dl = $urandom_range(0, 3);
      repeat (dl) begin
         chk("wait_out_rdy", i2c_out_rdy_o, 1);
         chk("wait_val", i2c_val_o, 0);
         @(posedge clk); @(negedge clk);
      end
      chk("wait_out_rdy", i2c_out_rdy_o, 1);
      i2c_out_val_i = 1'b1; i2c_out_err_i = err; i2c_out_data_i = d;
      @(posedge clk); @(negedge clk);
      i2c_out_val_i = 1'b0; i2c_out_err_i = 1'b0;
   endtask

   // full transaction; called just after a negedge with the DUT idle
   task automatic run_txn(input logic [NREQ-1:0] vals, input int nacks, input int hold,
                          input logic [7:0] rd, output int win);
      int hs0, gap;
      bit err;
      logic [7:0] d, last_d;
      last_d = '0;
      req_val_i = vals;
      #1;
      win = rr_pick(vals, m_last);
      chk("req_rdy", req_rdy_o, 32'(1) << win);
      @(posedge clk); @(negedge clk);
      chk("grant", grant_o, win);
      chk("busy", busy_o, 1);
      chk("req_rdy_busy", req_rdy_o, 0);
      hs0 = n_hs;
      for (int a = 0; a <= RETRIES; a++) begin
         err = a < nacks;
         d = err ? 8'($urandom) : rd;
         last_d = d;
         attempt(win, err, d);
         if (!(err && a < RETRIES)) break;
         gap = 0;
         while (!i2c_val_o && gap < 200) begin
            gap++;
            @(posedge clk); @(negedge clk);
         end
         chk("retry_gap", gap, RETRY_GAP);
         if (gap >= 200) break;
      end
      chk("attempts", n_hs - hs0, (nacks < RETRIES ? nacks : RETRIES) + 1);
      err = nacks > RETRIES;
      for (int c = 0; c <= hold; c++) begin
         chk("resp_val", resp_val_o, 32'(1) << win);
         chk("resp_err", resp_err_o, err);
         if (!f_wen[win]) chk("resp_data", resp_data_o, last_d);
         chk("resp_req_rdy", req_rdy_o, 0);
         chk("resp_i2c_val", i2c_val_o, 0);
         resp_rdy_i = (c == hold) ? NREQ'(1) << win : NREQ'($urandom) & ~(NREQ'(1) << win);
         @(posedge clk); @(negedge clk);
      end
      resp_rdy_i = '0;
      req_val_i = '0;
      m_last = win;
      if (err) m_fail++;
      chk("fail_cnt", fail_cnt_o, m_fail);
      chk("idle_busy", busy_o, 0);
      chk("idle_resp_val", resp_val_o, 0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rand_fields();
      do_reset();
      #1;
      chk_idle_zero("reset");
      chk("reset_req_rdy", req_rdy_o, 0);
      // directed single read from requester 2
      f_daddr[2] = 7'h50; f_addr[2] = 8'h10; f_wen[2] = 1'b0;
      run_txn(4'b0100, 0, 0, 8'hA5, w);
      chk("single_win", w, 2);
      // round-robin with every requester asserting from reset
      do_reset();
      for (int i = 0; i < 5; i++) begin
         rand_fields();
         run_txn(4'b1111, 0, 0, 8'($urandom), w);
         wins.push_back(w);
      end
      for (int i = 0; i < 5; i++) chk("rr_order", wins[i], rr_exp[i]);
      // one NACK then success
      rand_fields();
      run_txn(4'b1000, 1, 0, 8'($urandom), w);
      // persistent NACK exhausts the retries
      rand_fields();
      run_txn(4'b0010, 3, 0, 8'($urandom), w);
      // response backpressure while requester 1 also waits
      rand_fields();
      run_txn(4'b0011, 0, 20, 8'($urandom), w);
      chk("bp_owner", w, 0);
      run_txn(4'b0010, 0, 0, 8'($urandom), w);
      chk("bp_next", w, 1);
      // randomized traffic
      for (int i = 0; i < 20; i++) begin
         rand_fields();
         run_txn(NREQ'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 4),
                 8'($urandom), w);
      end
      // reset while waiting for the engine completion
      rand_fields();
      req_val_i = 4'b0100;
      @(posedge clk); @(negedge clk);
      req_val_i = '0;
      chk("mid_i2c_val", i2c_val_o, 1);
      i2c_rdy_i = 1'b1;
      @(posedge clk); @(negedge clk);
      i2c_rdy_i = 1'b0;
      chk("mid_out_rdy", i2c_out_rdy_o, 1);
      srst_i = 1'b1;
      i2c_out_val_i = 1'b1;
      @(posedge clk); @(negedge clk);
      srst_i = 1'b0;
      i2c_out_val_i = 1'b0;
      m_last = NREQ - 1;
      m_fail = 0;
      chk_idle_zero("mid_rst");
      for (int i = 0; i < 5; i++) begin
         chk("mid_rst_no_resp", resp_val_o, 0);
         @(posedge clk); @(negedge clk);
      end
      run_txn(4'b1111, 0, 0, 8'($urandom), w);
      chk("post_rst_win", w, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2c_arb.md
Name: i2c_arb

Overview:
- Round-robin arbiter and transaction sequencer in front of the single I2C master engine.
- Shares the engine between NREQ requesters, e.g. sensor poller, config loader and host CSR bridge.
- Latches one request at a time, issues it to the engine, and retries on NACK after a bus-idle gap.
- Returns the final read data or error to the originating requester only.

Parameters:
NREQ, 4, number of requesters (2..8)
RETRIES, 2, extra attempts after a NACK before reporting error (0..15)
RETRY_GAP, 64, idle clk_i cycles between a NACKed attempt and its retry (>=1)

Ports:
clk_i  in  1  clock
srst_i  in  1  reset, synchronous, active-high
req_val_i  in  NREQ  request valid, one bit per requester
req_daddr_i  in  7*NREQ  7-bit device address, requester k at [7k+6:7k]
req_addr_i  in  8*NREQ  register address, requester k at [8k+7:8k]
req_data_i  in  8*NREQ  write data, requester k at [8k+7:8k]
req_wen_i  in  NREQ  1=write, 0=read
req_rdy_o  out  NREQ  request accepted (one-hot or zero)
resp_val_o  out  NREQ  response valid (one-hot or zero)
resp_err_o  out  1  final attempt NACKed; qualified by resp_val_o
resp_data_o  out  8  read data; qualified by resp_val_o; undefined for writes
resp_rdy_i  in  NREQ  response accept, per requester
i2c_val_o  out  1  engine request valid
i2c_daddr_o  out  7  engine device address
i2c_addr_o  out  8  engine register address
i2c_data_o  out  8  engine write data
i2c_wen_o  out  1  engine write enable
i2c_rdy_i  in  1  engine request ready
i2c_out_val_i  in  1  engine completion valid
i2c_out_err_i  in  1  engine NACK flag
i2c_out_data_i  in  8  engine read data
i2c_out_rdy_o  out  1  engine completion accept
busy_o  out  1  state != IDLE
grant_o  out  $clog2(NREQ)  index of the owning requester; holds the last owner in IDLE
fail_cnt_o  out  16  saturating count of responses returned with resp_err_o=1

Behaviour:
- Reset values, applied on srst_i sampled high at a clk_i edge:
  - state=IDLE; all outputs 0.
  - Internal last-grant register = NREQ-1, so requester 0 has top priority after reset.
  - Attempt counter 0; gap counter 0.
- srst_i mid-transaction: abandon immediately. No response is delivered. An engine completion still pending is ignored; the engine is reset by the same srst_i.
- States and transitions:
  - IDLE:
    - Winner = first k with req_val_i[k]=1, searching last_grant+1, +2, … with wrap modulo NREQ.
    - req_rdy_o is combinational: one-hot at the winner, 0 if no request.
    - On fire: latch daddr/addr/data/wen, grant_o=k, attempts=0, go to ISSUE next cycle.
    - Minimum latency req fire -> i2c_val_o is 1 cycle.
  - ISSUE:
    - i2c_val_o=1 with the latched fields, held stable until i2c_rdy_i.
    - On i2c_val_o && i2c_rdy_i: go to WAIT.
  - WAIT:
    - i2c_out_rdy_o=1.
    - On i2c_out_val_i: latch i2c_out_err_i and i2c_out_data_i.
    - If err=1 and attempts<RETRIES: attempts+1, gap counter=RETRY_GAP-1, go to GAP.
    - Otherwise go to RESP.
  - GAP:
    - All engine outputs 0. Decrement the counter each cycle.
    - At 0, go to ISSUE, so exactly RETRY_GAP cycles are spent in GAP.
  - RESP:
    - resp_val_o[grant_o]=1; resp_err_o/resp_data_o driven from the latch and held stable.
    - On resp_rdy_i[grant_o]: last_grant=grant_o; fail_cnt_o+1 if err (saturates at 16'hFFFF); go to IDLE.
    - resp_rdy_i of other requesters is ignored.
- IDLE accepts only after RESP completes, so there is at most one transaction outstanding; the same requester cannot be re-granted in the RESP->IDLE cycle ahead of others.
- req_rdy_o is never asserted outside IDLE. A requester dropping req_val_i before grant is legal; it simply loses its turn.
- Data fields of requesters that are not selected are don't-care.
- A write with err=0 returns resp_data_o = last engine data (don't-care).
- RETRIES=0: the first NACK goes straight to RESP with err=1.

Test Plan:
- Single read: req 2 requests daddr=7'h50, addr=8'h10, wen=0; engine returns data 8'hA5, err=0. Expect:
  - req_rdy_o=4'b0100;
  - i2c_val_o one cycle after fire with daddr=7'h50, addr=8'h10;
  - resp_val_o=4'b0100, resp_data_o=8'hA5, resp_err_o=0;
  - fail_cnt_o stays 0.
- Round-robin: all 4 requesters assert continuously from reset, with an immediate-completing engine model. Expect the grant order 0,1,2,3,0 and no requester granted twice before the others.
- Retry success, RETRIES=2 and RETRY_GAP=64: the engine NACKs once, then ACKs. Expect:
  - exactly 64 cycles with i2c_val_o=0 between the completion handshake and the re-issue;
  - 2 engine transactions with identical fields;
  - resp_err_o=0.
- Retry exhaustion: the engine always NACKs. Expect exactly 3 engine transactions, then resp_err_o=1 and fail_cnt_o=1.
- Response backpressure: hold resp_rdy_i low 20 cycles while req 1 also requests. Expect:
  - resp_val_o and resp_data_o stable for 20 cycles;
  - req_rdy_o=0 throughout;
  - req 1 granted in the first IDLE cycle after the response handshake.
- Reset mid-WAIT: assert srst_i one cycle during WAIT. Expect:
  - next cycle all outputs 0, busy_o=0;
  - no resp_val_o pulse;
  - requester 0 wins the next arbitration.
